// File: rtl/axi4_lite_slave_regs_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and data width.
// Imported by the interface, the register core and the top-level slave.
package axi4_lite_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    // Out-of-range register indices answer SLVERR; everything else is OKAY.
    function automatic logic [1:0] index_resp(input int index, input int num_regs);
        return (index < num_regs) ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi4_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between the lite master and the register-file slave.
// The master modport drives requests; the slave modport drives ready/response.
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 6
);
    import axi4_lite_pkg::*;

    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic [2:0]            S_AXI_AWPROT;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0] S_AXI_WDATA;
    logic [STRB_WIDTH-1:0] S_AXI_WSTRB;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WREADY;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic [2:0]            S_AXI_ARPROT;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0] S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

endinterface

// File: rtl/axi4_lite_slave_regs_regfile_core.sv
// Register array with byte-strobe merge, per-register write pulse and a
// combinational read mux that returns zero for indices with no register.
module axi4_lite_regfile_core
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_index,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [STRB_WIDTH-1:0]          wr_strb,
    input  logic [IDX_W-1:0]               rd_index,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [DATA_WIDTH*NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // A commit with no strobes still pulses, so user logic sees every access.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            reg_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_wr_pulse[i] <= wr_en && (wr_index == IDX_W'(i));
                if (wr_en && (wr_index == IDX_W'(i))) begin
                    for (int k = 0; k < STRB_WIDTH; k++) begin
                        if (wr_strb[k]) begin
                            regs[i][8*k +: 8] <= wr_data[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[DATA_WIDTH*i +: DATA_WIDTH] = regs[i];
            if (rd_index == IDX_W'(i)) begin
                rd_data = regs[i];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register file: independent write and read channel FSMs in
// front of a strobe-merging register core whose contents are exported.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    axi4_lite_if.slave                     s_axi,
    output logic [DATA_WIDTH*NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    wr_state_t             wr_state;
    rd_state_t             rd_state;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic [1:0]            bresp_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  aw_ready, w_ready, ar_ready;
    logic                  aw_hs, w_hs;
    logic                  commit;
    logic [IDX_W-1:0]      commit_idx;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_WIDTH-1:0] commit_strb;
    logic [IDX_W-1:0]      aw_idx, ar_idx;
    logic                  unused_bits;

    assign aw_idx = s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
    assign ar_idx = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // Readies depend only on state, so no input reaches an output combinationally.
    assign aw_ready = (wr_state == WR_IDLE) || (wr_state == WR_DATA);
    assign w_ready  = (wr_state == WR_IDLE) || (wr_state == WR_ADDR);
    assign ar_ready = (rd_state == RD_IDLE);
    assign aw_hs    = s_axi.S_AXI_AWVALID && aw_ready;
    assign w_hs     = s_axi.S_AXI_WVALID && w_ready;

    assign s_axi.S_AXI_AWREADY = aw_ready;
    assign s_axi.S_AXI_WREADY  = w_ready;
    assign s_axi.S_AXI_BVALID  = (wr_state == WR_RESP);
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = ar_ready;
    assign s_axi.S_AXI_RVALID  = (rd_state == RD_DATA);
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;

    // Commit happens on the edge that completes whichever of AW/W arrives last.
    always_comb begin
        commit      = 1'b0;
        commit_idx  = aw_idx;
        commit_data = s_axi.S_AXI_WDATA;
        commit_strb = s_axi.S_AXI_WSTRB;
        unique case (wr_state)
            WR_IDLE: commit = aw_hs && w_hs;
            WR_ADDR: begin
                commit     = w_hs;
                commit_idx = aw_idx_q;
            end
            WR_DATA: begin
                commit      = aw_hs;
                commit_data = data_q;
                commit_strb = strb_q;
            end
            default: commit = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state <= WR_IDLE;
            aw_idx_q <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            bresp_q  <= index_resp(int'(commit_idx), NUM_REGS);
            wr_state <= WR_RESP;
        end else begin
            unique case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        aw_idx_q <= aw_idx;
                        wr_state <= WR_ADDR;
                    end else if (w_hs) begin
                        data_q   <= s_axi.S_AXI_WDATA;
                        strb_q   <= s_axi.S_AXI_WSTRB;
                        wr_state <= WR_DATA;
                    end
                end
                WR_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= wr_state;
            endcase
        end
    end

    // Read data is captured at the AR handshake, so a same-edge write is not visible.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state <= RD_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            unique case (rd_state)
                RD_IDLE: begin
                    if (s_axi.S_AXI_ARVALID) begin
                        rdata_q  <= rd_data;
                        rresp_q  <= index_resp(int'(ar_idx), NUM_REGS);
                        rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (s_axi.S_AXI_RREADY) begin
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    axi4_lite_regfile_core #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_core (
        .clk          (ACLK),
        .rst          (ARESET),
        .wr_en        (commit),
        .wr_index     (commit_idx),
        .wr_data      (commit_data),
        .wr_strb      (commit_strb),
        .rd_index     (ar_idx),
        .rd_data      (rd_data),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs: a vector table of write/readback
// records plus hand sequences for split AW/W, backpressure and mid-transaction reset.
module tb_axi4_lite_slave_regs;
    import axi4_lite_pkg::*;

    localparam int NUM_REGS   = 4;
    localparam int ADDR_WIDTH = 6;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
        logic [3:0]            strb;
        logic [1:0]            exp_resp;
        logic [3:0]            exp_pulse;
        logic [31:0]           exp_rdata;
    } vec_t;

    logic                 clk;
    logic                 rst;
    logic [127:0]         reg_out;
    logic [NUM_REGS-1:0]  reg_wr_pulse;
    int                   vectors_applied;
    int                   miscompares;
    vec_t                 vecs[8];

    axi4_lite_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    axi4_lite_slave_regs #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .ACLK         (clk),
        .ARESET       (rst),
        .s_axi        (bus.slave),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic axi_write(input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic [3:0] pulse, output logic ok);
        logic aw_pend, w_pend, aw_fire, w_fire;
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        ok      = 1'b1;
        resp    = 2'b11;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        for (int n = 0; n < 20 && (aw_pend || w_pend); n++) begin
            aw_fire = aw_pend && bus.S_AXI_AWREADY;
            w_fire  = w_pend && bus.S_AXI_WREADY;
            tick();
            if (aw_fire) begin
                aw_pend = 1'b0;
                bus.S_AXI_AWVALID = 1'b0;
            end
            if (w_fire) begin
                w_pend = 1'b0;
                bus.S_AXI_WVALID = 1'b0;
            end
        end
        pulse = reg_wr_pulse;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        if (aw_pend || w_pend) begin
            ok = 1'b0;
        end else begin
            for (int n = 0; n < 20 && !bus.S_AXI_BVALID; n++) tick();
            if (!bus.S_AXI_BVALID) begin
                ok = 1'b0;
            end else begin
                resp = bus.S_AXI_BRESP;
                bus.S_AXI_BREADY = 1'b1;
                tick();
                bus.S_AXI_BREADY = 1'b0;
            end
        end
    endtask

    task automatic axi_read(input logic [ADDR_WIDTH-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic ok);
        logic done;
        done = 1'b0;
        ok   = 1'b1;
        data = 32'hxxxx_xxxx;
        resp = 2'b11;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            done = bus.S_AXI_ARREADY;
            tick();
        end
        bus.S_AXI_ARVALID = 1'b0;
        for (int n = 0; n < 20 && done && !bus.S_AXI_RVALID; n++) tick();
        if (!done || !bus.S_AXI_RVALID) begin
            ok = 1'b0;
        end else begin
            data = bus.S_AXI_RDATA;
            resp = bus.S_AXI_RRESP;
            bus.S_AXI_RREADY = 1'b1;
            tick();
            bus.S_AXI_RREADY = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input int idx);
        logic [1:0]  bresp, rresp;
        logic [3:0]  pulse;
        logic [31:0] rdata;
        logic        wok, rok;
        axi_write(vecs[idx].addr, vecs[idx].data, vecs[idx].strb, bresp, pulse, wok);
        check_output($sformatf("vec%0d write_done", idx), 128'(wok), 128'(1));
        check_output($sformatf("vec%0d bresp", idx), 128'(bresp), 128'(vecs[idx].exp_resp));
        check_output($sformatf("vec%0d wr_pulse", idx), 128'(pulse), 128'(vecs[idx].exp_pulse));
        check_output($sformatf("vec%0d pulse_cleared", idx), 128'(reg_wr_pulse), 128'(0));
        axi_read(vecs[idx].addr, rdata, rresp, rok);
        check_output($sformatf("vec%0d read_done", idx), 128'(rok), 128'(1));
        check_output($sformatf("vec%0d rresp", idx), 128'(rresp), 128'(vecs[idx].exp_resp));
        check_output($sformatf("vec%0d rdata", idx), 128'(rdata), 128'(vecs[idx].exp_rdata));
    endtask

    initial begin
        logic        stable;
        logic [1:0]  resp, rresp;
        logic [3:0]  pulse;
        logic [31:0] rdata;
        logic        ok;

        vectors_applied = 0;
        miscompares     = 0;
        vecs[0] = '{6'h00, 32'h0101FFFF, 4'hF, RESP_OKAY,   4'b0001, 32'h0101FFFF};
        vecs[1] = '{6'h04, 32'hABCD0001, 4'hF, RESP_OKAY,   4'b0010, 32'hABCD0001};
        vecs[2] = '{6'h08, 32'hDEAD0011, 4'hF, RESP_OKAY,   4'b0100, 32'hDEAD0011};
        vecs[3] = '{6'h0C, 32'hBEEF0011, 4'hF, RESP_OKAY,   4'b1000, 32'hBEEF0011};
        vecs[4] = '{6'h00, 32'h12345678, 4'h5, RESP_OKAY,   4'b0001, 32'h0134FF78};
        vecs[5] = '{6'h10, 32'h11111111, 4'hF, RESP_SLVERR, 4'b0000, 32'h00000000};
        vecs[6] = '{6'h04, 32'hFFFFFFFF, 4'h0, RESP_OKAY,   4'b0010, 32'hABCD0001};
        vecs[7] = '{6'h07, 32'h00000077, 4'h1, RESP_OKAY,   4'b0010, 32'hABCD0077};

        rst = 1'b1;
        bus.S_AXI_AWADDR  = '0;
        bus.S_AXI_AWPROT  = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0;
        bus.S_AXI_WSTRB   = '0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = '0;
        bus.S_AXI_ARPROT  = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
        tick();
        tick();
        check_output("reset valids", 128'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 128'(0));
        check_output("reset resps", 128'({bus.S_AXI_BRESP, bus.S_AXI_RRESP}), 128'(0));
        check_output("reset rdata", 128'(bus.S_AXI_RDATA), 128'(0));
        check_output("reset reg_out", reg_out, 128'(0));
        check_output("reset pulse", 128'(reg_wr_pulse), 128'(0));
        rst = 1'b0;
        tick();
        check_output("readies after reset",
                     128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 128'(3'b111));

        for (int i = 0; i < 8; i++) apply_stimulus(i);
        check_output("reg_out after table", reg_out,
                     {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0077, 32'h0134FF78});

        // AW leads W by three cycles
        bus.S_AXI_AWADDR  = 6'h04;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        tick();
        tick();
        check_output("aw_first bvalid early", 128'(bus.S_AXI_BVALID), 128'(0));
        check_output("aw_first readies", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 128'(2'b01));
        check_output("aw_first reg1 held", 128'(reg_out[63:32]), 128'(32'hABCD0077));
        bus.S_AXI_WDATA  = 32'h5A5A0004;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        check_output("aw_first bvalid", 128'(bus.S_AXI_BVALID), 128'(1));
        check_output("aw_first reg1", 128'(reg_out[63:32]), 128'(32'h5A5A0004));
        check_output("aw_first pulse", 128'(reg_wr_pulse), 128'(4'b0010));
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        check_output("aw_first bvalid drop", 128'(bus.S_AXI_BVALID), 128'(0));

        // W leads AW by three cycles
        bus.S_AXI_WDATA  = 32'h0000C0DE;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        tick();
        tick();
        check_output("w_first bvalid early", 128'(bus.S_AXI_BVALID), 128'(0));
        check_output("w_first readies", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 128'(2'b10));
        check_output("w_first reg1 held", 128'(reg_out[63:32]), 128'(32'h5A5A0004));
        bus.S_AXI_AWADDR  = 6'h04;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        check_output("w_first bvalid", 128'(bus.S_AXI_BVALID), 128'(1));
        check_output("w_first reg1", 128'(reg_out[63:32]), 128'(32'h0000C0DE));
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;

        // Same-edge read and write of reg 2, then ten cycles of backpressure
        bus.S_AXI_AWADDR  = 6'h08;
        bus.S_AXI_WDATA   = 32'h00000055;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_ARADDR  = 6'h08;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_AWADDR = 6'h0C;
        bus.S_AXI_ARADDR = 6'h0C;
        bus.S_AXI_WDATA  = 32'hFFFFFFFF;
        check_output("collide rdata", 128'(bus.S_AXI_RDATA), 128'(32'hDEAD0011));
        check_output("collide valids", 128'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 128'(2'b11));
        check_output("collide reg2", 128'(reg_out[95:64]), 128'(32'h00000055));
        stable = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            stable &= bus.S_AXI_BVALID && bus.S_AXI_RVALID && (bus.S_AXI_BRESP == RESP_OKAY) &&
                      (bus.S_AXI_RRESP == RESP_OKAY) && (bus.S_AXI_RDATA == 32'hDEAD0011) &&
                      !bus.S_AXI_AWREADY && !bus.S_AXI_WREADY && !bus.S_AXI_ARREADY;
        end
        check_output("backpressure stable", 128'(stable), 128'(1));
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_BREADY  = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        check_output("backpressure release", 128'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 128'(0));
        check_output("reg3 untouched", 128'(reg_out[127:96]), 128'(32'hBEEF0011));

        // Reset while both channels hold a pending response
        bus.S_AXI_AWADDR  = 6'h00;
        bus.S_AXI_WDATA   = 32'h00000099;
        bus.S_AXI_ARADDR  = 6'h04;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        check_output("pending valids", 128'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 128'(2'b11));
        rst = 1'b1;
        tick();
        check_output("midreset valids", 128'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 128'(0));
        check_output("midreset reg_out", reg_out, 128'(0));
        rst = 1'b0;
        tick();
        check_output("midreset readies",
                     128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 128'(3'b111));

        axi_write(6'h0C, 32'hCAFEF00D, 4'hF, resp, pulse, ok);
        check_output("post write ok", 128'({ok, resp, pulse}), 128'({1'b1, RESP_OKAY, 4'b1000}));
        axi_read(6'h0C, rdata, rresp, ok);
        check_output("post read", 128'({ok, rresp, rdata}), 128'({1'b1, RESP_OKAY, 32'hCAFEF00D}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
